hd_hamming_tx: RTL and testbench

//  Transmit side of the HD Hamming(7,4) link: buffers 4-bit data nibbles, encodes each into a
//  7-bit codeword and serialises it MSB-first over a 1-bit valid/ready stream.

---
 rtl/hd_pkg.sv | 27 ++
 rtl/hd_hamming74_enc.sv | 24 ++
 rtl/hd_hamming_tx.sv | 165 ++++++++++++++++
 tb/tb_hd_hamming_tx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hd_pkg.sv
// Shared constants, types and parity helper for the HD Hamming(7,4) link.
package hd_pkg;

  localparam int CW_W   = 7;
  localparam int DATA_W = 4;
  localparam int ERR_W  = 3;

  // Data bits are ordered {x1,x2,x3,x4} = data[3:0]
  localparam logic [DATA_W-1:0] P1_MASK = 4'b1110;
  localparam logic [DATA_W-1:0] P2_MASK = 4'b1101;
  localparam logic [DATA_W-1:0] P3_MASK = 4'b1011;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef struct packed {
    logic [ERR_W-1:0]  err;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  function automatic logic parity4(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
    return ^(d & m);
  endfunction

endpackage

// File: rtl/hd_hamming74_enc.sv
// Combinational Hamming(7,4) encoder with optional single-bit error flip.
module hd_hamming74_enc
  import hd_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [ERR_W-1:0]  err,
  output logic [CW_W-1:0]   cw
);

  logic [CW_W-1:0] clean_s;
  logic [CW_W-1:0] flip_s;

  // Build {p1,p2,p3,x1..x4}, then flip bit err-1 when err is non-zero
  always_comb begin
    clean_s = {parity4(data, P1_MASK), parity4(data, P2_MASK), parity4(data, P3_MASK), data};
    if (err != 3'd0) begin
      flip_s = 7'b000_0001 << (err - 3'd1);
    end else begin
      flip_s = 7'b000_0000;
    end
    cw = clean_s ^ flip_s;
  end

endmodule

// File: rtl/hd_hamming_tx.sv
// HD Hamming(7,4) transmitter: nibble FIFO, encoder and MSB-first serialiser.
module hd_hamming_tx
  import hd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        in_data,
  input  logic [2:0]        in_err,
  output logic              in_ready,
  output logic              out_valid,
  output logic              out_bit,
  output logic              out_sof,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  err_frames
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNTF_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNTF_W-1:0] FULL_CNT = CNTF_W'(FIFO_DEPTH);
  localparam logic [CNTF_W-1:0] ONE_CNT  = CNTF_W'(1);
  localparam logic [PTR_W-1:0]  ONE_PTR  = PTR_W'(1);

  fifo_entry_t        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTF_W-1:0]  count_q, count_d;
  logic               in_ready_q, in_ready_d;

  state_e             state_q, state_d;
  logic [CW_W-1:0]    sreg_q, sreg_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               flag_q, flag_d;
  logic [CNT_W-1:0]   err_frames_q, err_frames_d;

  logic               push_s;
  logic               pop_s;
  fifo_entry_t        head_s;
  logic [CW_W-1:0]    head_cw_s;

  assign push_s = in_valid & in_ready_q;
  assign head_s = mem_q[rd_ptr_q];

  hd_hamming74_enc u_enc (
    .data (head_s.data),
    .err  (head_s.err),
    .cw   (head_cw_s)
  );

  // Serialiser FSM; a pop always loads the head codeword, so frames run back-to-back
  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    cnt_d        = cnt_q;
    flag_d       = flag_q;
    err_frames_d = err_frames_q;
    pop_s        = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop_s   = 1'b1;
          sreg_d  = head_cw_s;
          cnt_d   = 3'd6;
          flag_d  = (head_s.err != 3'd0);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          if (cnt_q != 3'd0) begin
            sreg_d = {sreg_q[CW_W-2:0], 1'b0};
            cnt_d  = cnt_q - 3'd1;
          end else begin
            if (flag_q && (err_frames_q != {CNT_W{1'b1}})) begin
              err_frames_d = err_frames_q + CNT_W'(1);
            end else begin
              err_frames_d = err_frames_q;
            end
            if (count_q != '0) begin
              pop_s   = 1'b1;
              sreg_d  = head_cw_s;
              cnt_d   = 3'd6;
              flag_d  = (head_s.err != 3'd0);
              state_d = SHIFT;
            end else begin
              flag_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO pointer/occupancy update; in_ready is registered from the next occupancy
  always_comb begin
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + ONE_PTR;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ONE_PTR;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != FULL_CNT);
  end

  // FIFO storage (no reset needed: occupancy gates every read)
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= '{err: in_err, data: in_data};
    end
  end

  // State registers; reset drops the in-flight frame and every queued nibble
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b0;
      state_q      <= IDLE;
      sreg_q       <= '0;
      cnt_q        <= 3'd0;
      flag_q       <= 1'b0;
      err_frames_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      in_ready_q   <= in_ready_d;
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      flag_q       <= flag_d;
      err_frames_q <= err_frames_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q == SHIFT);
  assign out_bit    = out_valid & sreg_q[CW_W-1];
  assign out_sof    = out_valid & (cnt_q == 3'd6);
  assign busy       = (count_q != '0) | (state_q == SHIFT);
  assign err_frames = err_frames_q;

endmodule

// File: tb/tb_hd_hamming_tx.sv
// Directed self-checking bench for hd_hamming_tx with hand-computed codewords.
module tb_hd_hamming_tx;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic [2:0] in_err;
  logic       in_ready;
  logic       out_valid;
  logic       out_bit;
  logic       out_sof;
  logic       out_ready;
  logic       busy;
  logic [7:0] err_frames;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] got;

  hd_hamming_tx #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_err     (in_err),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_bit    (out_bit),
    .out_sof    (out_sof),
    .out_ready  (out_ready),
    .busy       (busy),
    .err_frames (err_frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sof(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (out_valid && out_sof) break;
      tick();
    end
    chk(tag, {31'd0, out_valid & out_sof}, 32'd1);
  endtask

  // Receive bits first..last of a frame (out_ready must be high), checking each
  task automatic rx_bits(input string tag, input logic [6:0] exp, input int first, input int last,
                         inout logic [6:0] word);
    for (int i = first; i <= last; i++) begin
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_bit"}, {31'd0, out_bit}, {31'd0, exp[6-i]});
      chk({tag, "_sof"}, {31'd0, out_sof}, (i == 0) ? 32'd1 : 32'd0);
      word[6-i] = out_bit;
      tick();
    end
  endtask

  // Independent syndrome decoder for {p1,p2,p3,x1,x2,x3,x4}
  function automatic logic [3:0] hd_decode(input logic [6:0] cw);
    logic [2:0] s;
    logic [3:0] d;
    s[2] = cw[6] ^ cw[3] ^ cw[2] ^ cw[1];
    s[1] = cw[5] ^ cw[3] ^ cw[2] ^ cw[0];
    s[0] = cw[4] ^ cw[3] ^ cw[1] ^ cw[0];
    d = cw[3:0];
    case (s)
      3'b111:  d[3] = ~d[3];
      3'b110:  d[2] = ~d[2];
      3'b101:  d[1] = ~d[1];
      3'b011:  d[0] = ~d[0];
      default: d = cw[3:0];
    endcase
    return d;
  endfunction

  task automatic push1(input logic [3:0] d, input logic [2:0] e);
    in_valid = 1'b1;
    in_data  = d;
    in_err   = e;
    tick();
    in_valid = 1'b0;
    in_err   = 3'd0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; in_err = 3'd0; out_ready = 1'b0;
    got = 7'd0;

    // 1: reset state
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_bit", {31'd0, out_bit}, 32'd0);
    chk("rst_out_sof", {31'd0, out_sof}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err_frames", {24'd0, err_frames}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // 2: single frame 4'b1011 -> 7'h1B, one-cycle latency
    out_ready = 1'b1;
    push1(4'b1011, 3'd0);
    chk("t2_lat_idle", {31'd0, out_valid}, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t2_lat_sof", {31'd0, out_sof}, 32'd1);
    rx_bits("t2", 7'h1B, 0, 6, got);
    chk("t2_word", {25'd0, got}, 32'h1B);
    chk("t2_done_valid", {31'd0, out_valid}, 32'd0);
    chk("t2_done_busy", {31'd0, busy}, 32'd0);

    // 3: three back-to-back frames with no bubble
    out_ready = 1'b0;
    push1(4'h0, 3'd0);
    push1(4'hF, 3'd0);
    push1(4'b0001, 3'd0);
    wait_sof("t3_sof");
    out_ready = 1'b1;
    rx_bits("t3a", 7'h00, 0, 6, got);
    rx_bits("t3b", 7'h7F, 0, 6, got);
    rx_bits("t3c", 7'h31, 0, 6, got);
    chk("t3_done_valid", {31'd0, out_valid}, 32'd0);
    chk("t3_err_frames", {24'd0, err_frames}, 32'd0);

    // 4: error injection on bit 6, counter and loop-back decode
    push1(4'b1011, 3'd7);
    wait_sof("t4_sof");
    rx_bits("t4", 7'h5B, 0, 6, got);
    chk("t4_word", {25'd0, got}, 32'h5B);
    chk("t4_err_frames", {24'd0, err_frames}, 32'd1);
    chk("t4_decode", {28'd0, hd_decode(got)}, 32'hB);

    // 5: 5-cycle stall mid-frame while filling the FIFO past its depth
    push1(4'h6, 3'd0);
    wait_sof("t5_sof");
    rx_bits("t5a", 7'h36, 0, 2, got);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 4'h2 + 4'(i);
      if (i == 3) in_data = 4'h5;
      chk("t5_ready_pre", {31'd0, in_ready}, 32'd1);
      tick();
      chk("t5_hold_bit", {31'd0, out_bit}, 32'd0);
      chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t5_hold_sof", {31'd0, out_sof}, 32'd0);
    end
    chk("t5_full", {31'd0, in_ready}, 32'd0);
    in_data = 4'h7;
    tick();
    chk("t5_full2", {31'd0, in_ready}, 32'd0);
    chk("t5_hold_bit5", {31'd0, out_bit}, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rx_bits("t5a", 7'h36, 3, 6, got);
    chk("t5a_word", {25'd0, got}, 32'h36);
    rx_bits("t5b", 7'h52, 0, 6, got);
    rx_bits("t5c", 7'h63, 0, 6, got);
    rx_bits("t5d", 7'h64, 0, 6, got);
    rx_bits("t5e", 7'h55, 0, 6, got);
    chk("t5_no_extra", {31'd0, out_valid}, 32'd0);
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);

    // 6: reset during bit 3 with two nibbles queued
    out_ready = 1'b0;
    push1(4'h9, 3'd0);
    push1(4'hA, 3'd1);
    push1(4'hC, 3'd0);
    wait_sof("t6_sof");
    out_ready = 1'b1;
    rx_bits("t6a", 7'h49, 0, 2, got);
    rst = 1'b1;
    tick();
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_err_frames", {24'd0, err_frames}, 32'd0);
    rst = 1'b0;
    tick();
    chk("t6_rel_busy", {31'd0, busy}, 32'd0);
    chk("t6_rel_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rel_ready", {31'd0, in_ready}, 32'd1);
    push1(4'b0001, 3'd0);
    chk("t6_lat_idle", {31'd0, out_valid}, 32'd0);
    tick();
    rx_bits("t6b", 7'h31, 0, 6, got);
    chk("t6_empty", {31'd0, out_valid}, 32'd0);
    chk("t6_empty_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
